// File: rtl/vga_cap_pkg.sv
// vga_cap_pkg: shared geometry defaults, capture state encoding and {B,G,R} field slices.
package vga_cap_pkg;
    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int FRAME_PIXELS = H_ACTIVE_DEF * V_ACTIVE_DEF;
    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE} cap_state_t;
    localparam int B_HI = 23;
    localparam int B_LO = 16;
    localparam int G_HI = 15;
    localparam int G_LO = 8;
    localparam int R_HI = 7;
    localparam int R_LO = 0;
endpackage

// File: rtl/vga_timing_tracker.sv
// vga_timing_tracker: registers the VGA stream, recovers X/Y, checks frame geometry and tracks lock.
module vga_timing_tracker
    import vga_cap_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        iVGA_CLK,
    input  logic        iRST_n,
    input  logic        iHS,
    input  logic        iVS,
    input  logic        iBLANK_n,
    input  logic [7:0]  iB,
    input  logic [7:0]  iG,
    input  logic [7:0]  iR,
    output logic [23:0] pixel,
    output logic        active,
    output logic [10:0] pixX,
    output logic [10:0] pixY,
    output logic        frame_start,
    output logic        frame_good,
    output logic        frame_bad,
    output logic        locked
);
    localparam int GW = $clog2(LOCK_FRAMES + 1);
    logic s_hs, s_vs, s_blank, d_hs, d_vs, d_blank;
    logic [23:0] s_bgr;
    logic [10:0] xCnt, yCnt;
    logic lineBad, seenVs, hsFall, blankFall, frameOk;
    logic [GW-1:0] goodCnt, goodNext;
    always_comb begin
        hsFall      = d_hs & ~s_hs;
        blankFall   = d_blank & ~s_blank;
        frame_start = d_vs & ~s_vs;
        pixX        = (frame_start || hsFall) ? 11'd0 : xCnt;
        pixY        = frame_start ? 11'd0 : yCnt;
        frameOk     = (yCnt == 11'(V_ACTIVE)) && !lineBad;
        frame_good  = frame_start && seenVs && frameOk;
        frame_bad   = frame_start && seenVs && !frameOk;
        goodNext    = (goodCnt == GW'(LOCK_FRAMES)) ? goodCnt : goodCnt + GW'(1);
        pixel       = s_bgr;
        active      = s_blank;
    end
    // The first VS edge after reset only opens a frame; seenVs gates the check.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            {s_hs, s_vs, s_blank, d_hs, d_vs, d_blank} <= '0;
            s_bgr   <= '0;
            xCnt    <= '0;
            yCnt    <= '0;
            lineBad <= 1'b0;
            seenVs  <= 1'b0;
            goodCnt <= '0;
            locked  <= 1'b0;
        end else begin
            {s_hs, s_vs, s_blank} <= {iHS, iVS, iBLANK_n};
            {d_hs, d_vs, d_blank} <= {s_hs, s_vs, s_blank};
            s_bgr[B_HI:B_LO] <= iB;
            s_bgr[G_HI:G_LO] <= iG;
            s_bgr[R_HI:R_LO] <= iR;
            xCnt    <= (s_blank && pixX != 11'h7FF) ? pixX + 11'd1 : pixX;
            yCnt    <= frame_start ? 11'd0 : yCnt + {10'd0, blankFall};
            lineBad <= !frame_start && (lineBad || (blankFall && xCnt != 11'(H_ACTIVE)));
            seenVs  <= seenVs || frame_start;
            goodCnt <= frame_bad ? '0 : frame_good ? goodNext : goodCnt;
            locked  <= (frame_good || frame_bad) ? (frame_good && goodNext == GW'(LOCK_FRAMES)) : locked;
        end
    end
endmodule

// File: rtl/vga_frame_capture.sv
// vga_frame_capture: captures one full frame of a locked VGA stream into an external RAM write port.
module vga_frame_capture
    import vga_cap_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int ADDR_W      = 19,
    parameter int LOCK_FRAMES = 2
) (
    input  logic              iVGA_CLK,
    input  logic              iRST_n,
    input  logic              iHS,
    input  logic              iVS,
    input  logic              iBLANK_n,
    input  logic [7:0]        iB,
    input  logic [7:0]        iG,
    input  logic [7:0]        iR,
    input  logic              iCapReq,
    output logic              oCapBusy,
    output logic              oCapDone,
    output logic              oWrEn,
    output logic [ADDR_W-1:0] oWrAddr,
    output logic [23:0]       oWrData,
    output logic [10:0]       oPixX,
    output logic [10:0]       oPixY,
    output logic              oLocked,
    output logic              oFrameErr
);
    localparam logic [ADDR_W-1:0] FRAME = ADDR_W'(H_ACTIVE * V_ACTIVE);
    cap_state_t state, stateNext;
    logic [ADDR_W-1:0] addr, addrNext;
    logic [23:0] pixel;
    logic [10:0] pixX, pixY;
    logic active, frame_start, frame_good, frame_bad, wrNext, doneNext;
    vga_timing_tracker #(
        .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .LOCK_FRAMES(LOCK_FRAMES)
    ) tracker (
        .iVGA_CLK(iVGA_CLK), .iRST_n(iRST_n), .iHS(iHS), .iVS(iVS), .iBLANK_n(iBLANK_n),
        .iB(iB), .iG(iG), .iR(iR), .pixel(pixel), .active(active), .pixX(pixX), .pixY(pixY),
        .frame_start(frame_start), .frame_good(frame_good), .frame_bad(frame_bad), .locked(oLocked)
    );
    assign oCapBusy = (state != IDLE);
    always_comb begin
        stateNext = state;
        addrNext  = addr;
        wrNext    = 1'b0;
        doneNext  = 1'b0;
        unique case (state)
            IDLE:    stateNext = iCapReq ? ARMED : IDLE;
            ARMED:   if (frame_start && oLocked) begin
                         stateNext = CAPTURE;
                         addrNext  = '0;
                     end
            CAPTURE: if (frame_start) begin
                         stateNext = frame_good ? IDLE : ARMED;
                         doneNext  = frame_good;
                     end else if (active && addr < FRAME) begin
                         wrNext   = 1'b1;
                         addrNext = addr + ADDR_W'(1);
                     end
            default: stateNext = IDLE;
        endcase
    end
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) state <= IDLE;
        else         state <= stateNext;
    end
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            addr      <= '0;
            oWrEn     <= 1'b0;
            oWrAddr   <= '0;
            oWrData   <= '0;
            oPixX     <= '0;
            oPixY     <= '0;
            oCapDone  <= 1'b0;
            oFrameErr <= 1'b0;
        end else begin
            addr      <= addrNext;
            oWrEn     <= wrNext;
            oWrAddr   <= addr;
            oWrData   <= pixel;
            oPixX     <= pixX;
            oPixY     <= pixY;
            oCapDone  <= doneNext;
            oFrameErr <= frame_bad;
        end
    end
endmodule
